// File: rtl/ultrasonic_ranger_pkg.sv
// Shared ranging definitions: FSM encoding and default timing for the 12.25 MHz domain.
package ultrasonic_ranger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } state_e;

  localparam int unsigned RANGE_CLK_HZ      = 12_250_000;
  localparam int unsigned CYCLES_PER_CM     = 350;

  localparam int unsigned DEF_WIDTH_W       = 16;
  localparam int unsigned DEF_TRIG_CYCLES   = 123;
  localparam int unsigned DEF_PERIOD_CYCLES = 735_000;
  localparam int unsigned DEF_RISE_TIMEOUT  = 61_250;

endpackage

// File: rtl/ultrasonic_ranger_sync_edge.sv
// Two-flop synchroniser for the raw echo pin plus registered rise/fall pulses.
// A pin edge shows up on rise_o/fall_o three clk_i edges later.
module ultrasonic_ranger_sync_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  logic s1_d, s2_d, s3_d, rise_d, fall_d;

  // Next values: shift the pin through the chain, compare the last two stages.
  always_comb begin
    s1_d   = d_i;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // Synchroniser and edge registers, all clear on reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranging front-end: fires the trigger, times the echo, emits one sample per ping.
module ultrasonic_ranger
  import ultrasonic_ranger_pkg::*;
#(
  parameter int unsigned WIDTH_W       = DEF_WIDTH_W,
  parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned RISE_TIMEOUT  = DEF_RISE_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic               echo_i,
  output logic               trig_o,
  output logic [WIDTH_W-1:0] width_o,
  output logic               ready_o,
  output logic               timeout_o,
  output logic               busy_o
);

  // One timer serves both the trigger high time and the rise timeout.
  localparam int unsigned TMR_MAX = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned PER_W   = $clog2(PERIOD_CYCLES);

  localparam logic [TMR_W-1:0]   TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0]   RISE_LAST = TMR_W'(RISE_TIMEOUT - 1);
  localparam logic [PER_W-1:0]   PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] CNT_MAX   = '1;

  // A ping (trigger + worst-case wait + saturated echo) must fit inside one period.
  if (PERIOD_CYCLES <= TRIG_CYCLES + RISE_TIMEOUT + (1 << WIDTH_W)) begin : g_period_check
    $error("PERIOD_CYCLES too short for TRIG_CYCLES + RISE_TIMEOUT + 2**WIDTH_W");
  end

  logic echo_rise, echo_fall;

  ultrasonic_ranger_sync_edge u_sync (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .d_i     (echo_i),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  state_e             state_q, state_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               trig_q, trig_d;
  logic               ready_q, ready_d;
  logic               timeout_q, timeout_d;

  // Next-state and output logic; saturation beats fall, rise beats timeout.
  always_comb begin
    state_d   = state_q;
    per_d     = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    trig_d    = trig_q;
    width_d   = width_q;
    timeout_d = timeout_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_TRIG;
          trig_d  = 1'b1;
          per_d   = '0;
          tmr_d   = '0;
        end
      end
      ST_TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          trig_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          cnt_d   = WIDTH_W'(1);
        end else if (tmr_q == RISE_LAST) begin
          state_d   = ST_HOLDOFF;
          width_d   = '0;
          timeout_d = 1'b1;
          ready_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (cnt_q == CNT_MAX) begin
          state_d   = ST_HOLDOFF;
          width_d   = CNT_MAX;
          timeout_d = 1'b1;
          ready_d   = 1'b1;
        end else if (echo_fall) begin
          state_d   = ST_HOLDOFF;
          width_d   = cnt_q;
          timeout_d = 1'b0;
          ready_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // The period counter wrap re-arms, so pings stay exactly one period apart.
        if (per_q == PER_LAST) begin
          if (enable_i) begin
            state_d = ST_TRIG;
            trig_d  = 1'b1;
            per_d   = '0;
            tmr_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and output registers; reset aborts any ping in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      per_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      width_q   <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      trig_q    <= trig_d;
      width_q   <= width_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  assign trig_o    = trig_q;
  assign width_o   = width_q;
  assign ready_o   = ready_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened timing so whole periods fit in the run.
module tb_ultrasonic_ranger;

  localparam int W    = 10;
  localparam int TRIG = 123;
  localparam int RISE = 600;
  localparam int PER  = 2000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         echo = 1'b0;
  logic         trig, ready, tmo, busy;
  logic [W-1:0] width;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .WIDTH_W      (W),
    .TRIG_CYCLES  (TRIG),
    .PERIOD_CYCLES(PER),
    .RISE_TIMEOUT (RISE)
  ) u_dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .enable_i (en),
    .echo_i   (echo),
    .trig_o   (trig),
    .width_o  (width),
    .ready_o  (ready),
    .timeout_o(tmo),
    .busy_o   (busy)
  );

  typedef struct {
    int delay;   // cycles after trigger fall before echo rises
    int high;    // echo high cycles, 0 = no echo
    int exp_w;
    int exp_to;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0, rise_n = 0, fall_n = 0, rise_cyc = 0, fall_cyc = 0, rdy_n = 0;
  int last_w = 0, last_to = 0, exp_rdy = 0, prev_rise = 0;
  bit trig_prev = 1'b0, have_prev = 1'b0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Advance to the next falling edge and log trigger edges and ready strobes.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (trig && !trig_prev) begin rise_n++; rise_cyc = cyc; end
      if (!trig && trig_prev) begin fall_n++; fall_cyc = cyc; end
      trig_prev = trig;
      if (ready) begin rdy_n++; last_w = int'(width); last_to = int'(tmo); end
    end
  endtask

  task automatic wait_rise(input string name, input int budget);
    int n0 = rise_n;
    int k = 0;
    while (rise_n == n0 && k < budget) begin tick(); k++; end
    check({name, "_trig_rise_seen"}, int'(rise_n != n0), 1);
    if (have_prev) check({name, "_period"}, rise_cyc - prev_rise, PER);
    prev_rise = rise_cyc;
    have_prev = 1'b1;
    check({name, "_ready_count"}, rdy_n, exp_rdy);
  endtask

  task automatic wait_fall(input string name);
    int n0 = fall_n;
    int k = 0;
    while (fall_n == n0 && k < TRIG + 20) begin tick(); k++; end
    check({name, "_trig_fall_seen"}, int'(fall_n != n0), 1);
    check({name, "_trig_high"}, fall_cyc - rise_cyc, TRIG);
  endtask

  task automatic wait_ready(input string name, input int r0);
    int k = 0;
    while (rdy_n == r0 && k < 3000) begin tick(); k++; end
    check({name, "_ready_seen"}, int'(rdy_n != r0), 1);
    exp_rdy = r0 + 1;
  endtask

  task automatic ping(input string name, input vec_t v);
    int r0;
    wait_rise(name, PER + 200);
    check({name, "_busy"}, int'(busy), 1);
    wait_fall(name);
    r0 = rdy_n;
    tick(v.delay);
    if (v.high > 0) begin
      echo = 1'b1;
      tick(v.high);
      echo = 1'b0;
    end
    wait_ready(name, r0);
    check({name, "_width"}, last_w, v.exp_w);
    check({name, "_timeout"}, last_to, v.exp_to);
  endtask

  vec_t vecs[9];

  initial begin
    int r0, n0;
    vecs[0] = '{50, 700, 700, 0};     // plain echo
    vecs[1] = '{10, 1, 1, 0};         // shortest echo
    vecs[2] = '{0, 400, 400, 0};      // echo right after trigger fall
    vecs[3] = '{596, 100, 100, 0};    // rise lands on the timeout cycle: rise wins
    vecs[4] = '{597, 100, 0, 1};      // one cycle later: timeout
    vecs[5] = '{0, 0, 0, 1};          // no echo
    vecs[6] = '{20, 1022, 1022, 0};   // just below saturation
    vecs[7] = '{20, 1023, 1023, 1};   // fall together with saturation
    vecs[8] = '{20, 1200, 1023, 1};   // stuck high, saturates without wrap

    // Reset state
    tick(3);
    check("rst_trig", int'(trig), 0);
    check("rst_width", int'(width), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_timeout", int'(tmo), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", int'(busy), 0);
    check("idle_trig", int'(trig), 0);

    en = 1'b1;
    for (int i = 0; i < 9; i++) ping($sformatf("vec%0d", i), vecs[i]);

    // Glitch in HOLDOFF, then echo already high when the next trigger fires
    tick(20);
    echo = 1'b1; tick(2); echo = 1'b0;
    tick(20);
    echo = 1'b1;
    wait_rise("stale", PER + 200);
    wait_fall("stale");
    r0 = rdy_n;
    tick(30); echo = 1'b0;
    tick(40); echo = 1'b1;
    tick(300); echo = 1'b0;
    wait_ready("stale", r0);
    check("stale_width", last_w, 300);
    check("stale_timeout", last_to, 0);

    // enable dropped mid-MEASURE: sample completes, then IDLE
    wait_rise("endrop", PER + 200);
    wait_fall("endrop");
    r0 = rdy_n;
    tick(10); echo = 1'b1;
    tick(50); en = 1'b0;
    tick(100); echo = 1'b0;
    wait_ready("endrop", r0);
    check("endrop_width", last_w, 150);
    check("endrop_timeout", last_to, 0);
    n0 = rise_n;
    tick(PER + 300);
    check("endrop_no_trig", rise_n - n0, 0);
    check("endrop_busy", int'(busy), 0);
    check("endrop_ready_count", rdy_n, exp_rdy);

    // Reset while the trigger is high
    have_prev = 1'b0;
    en = 1'b1;
    wait_rise("rst_trig", 10);
    tick(20);
    check("in_trig_trig", int'(trig), 1);
    rst_n = 1'b0;
    #1;
    check("rst_trig_trig", int'(trig), 0);
    check("rst_trig_busy", int'(busy), 0);
    tick(2);
    rst_n = 1'b1;

    // Reset mid-MEASURE: no sample, then a fresh ping
    have_prev = 1'b0;
    wait_rise("rst_meas", 20);
    wait_fall("rst_meas");
    r0 = rdy_n;
    tick(10); echo = 1'b1;
    tick(100);
    rst_n = 1'b0;
    #1;
    check("rst_meas_trig", int'(trig), 0);
    check("rst_meas_ready", int'(ready), 0);
    check("rst_meas_width", int'(width), 0);
    check("rst_meas_busy", int'(busy), 0);
    echo = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("rst_meas_no_emit", rdy_n, r0);
    have_prev = 1'b0;
    ping("post_rst", '{15, 200, 200, 0});

    tick(5);
    check("final_ready_count", rdy_n, exp_rdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
